// File: rtl/y_conv_arbiter.sv
// Two-requester round-robin arbiter with burst lock feeding one
// RGB666-to-4-bit-luma converter and a single registered output beat.
module y_conv_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [17:0] s0_rgb,
   input  logic        s0_last,
   input  logic        s1_valid,
   output logic        s1_ready,
   input  logic [17:0] s1_rgb,
   input  logic        s1_last,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [3:0]  m_y,
   output logic        m_id,
   output logic        m_last
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]  state;
   logic        owner;
   logic        last_owner;
   logic        go;
   logic        acc;
   logic [17:0] sel_rgb;
   logic        sel_last;
   logic [5:0]  r, g, b;
   logic [5:0]  sum;
   logic [3:0]  y_next;

   // Output register frees up when empty or being drained this cycle.
   assign go       = !m_valid || m_ready;
   assign s0_ready = (state == BURST) && !owner && go;
   assign s1_ready = (state == BURST) &&  owner && go;
   assign acc      = (s0_valid && s0_ready) || (s1_valid && s1_ready);

   assign sel_rgb  = owner ? s1_rgb  : s0_rgb;
   assign sel_last = owner ? s1_last : s0_last;

   assign {r, g, b} = sel_rgb;
   assign sum    = (r >> 2) + (g >> 1) + (b >> 2);
   assign y_next = 4'(sum >> 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         m_valid    <= 1'b0;
         m_y        <= 4'd0;
         m_id       <= 1'b0;
         m_last     <= 1'b0;
      end else begin
         if (acc) begin
            m_valid <= 1'b1;
            m_y     <= y_next;
            m_id    <= owner;
            m_last  <= sel_last;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (s0_valid || s1_valid) begin
                  state <= BURST;
                  // Contested: the requester that did not finish last wins.
                  owner <= (s0_valid && s1_valid) ? !last_owner : s1_valid;
               end
            end
            BURST: begin
               if (acc && sel_last) begin
                  state      <= IDLE;
                  last_owner <= owner;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
